// File: rtl/scoreboard_pkg.sv
// scoreboard_pkg: segment encodings and scan FSM state shared by the scoreboard display blocks.
package scoreboard_pkg;
  typedef enum logic {ST_BLANK, ST_ON} state_e;
  localparam logic [6:0] SEG_0    = 7'b0111111;
  localparam logic [6:0] SEG_1    = 7'b0000110;
  localparam logic [6:0] SEG_2    = 7'b1011011;
  localparam logic [6:0] SEG_3    = 7'b1001111;
  localparam logic [6:0] SEG_4    = 7'b1100110;
  localparam logic [6:0] SEG_5    = 7'b1101101;
  localparam logic [6:0] SEG_6    = 7'b1111101;
  localparam logic [6:0] SEG_7    = 7'b0000111;
  localparam logic [6:0] SEG_8    = 7'b1111111;
  localparam logic [6:0] SEG_9    = 7'b1101111;
  localparam logic [6:0] SEG_DASH = 7'b1000000;
endpackage

// File: rtl/scoreboard_seg_decode.sv
// scoreboard_seg_decode: BCD to {g,f,e,d,c,b,a} segments; non-decimal codes show a dash.
module scoreboard_seg_decode
  import scoreboard_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);
  always_comb begin
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end
endmodule

// File: rtl/scoreboard_scan_ctrl.sv
// scoreboard_scan_ctrl: multiplexed 7-segment scan with blanking, PWM brightness and frame-synchronous update.
// Define SCOREBOARD_LZ_BLANK_EN to blank zero-valued tens digits.
module scoreboard_scan_ctrl
  import scoreboard_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int PRESCALE     = 1000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  input  logic [4*NUM_DIGITS-1:0] digit_bcd,
  input  logic                    load,
  input  logic [3:0]              brightness,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    upd_pending,
  output logic                    frame_start
);
  localparam int CW  = $clog2(PRESCALE);
  localparam int IW  = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam int SUB = (PRESCALE - BLANK_CYCLES) / 16;
  localparam int SW  = SUB > 1 ? $clog2(SUB) : 1;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  state_e                  state_q, state_d;
  logic [3:0]              bright_q, bright_d;
  logic [3:0]              step_q, step_d;
  logic [SW-1:0]           sub_q, sub_d;
  logic [4*NUM_DIGITS-1:0] active_q, active_d, pending_q, pending_d;
  logic                    upd_q, upd_d, fs_q, fs_d;
  logic [6:0]              seg_q, seg_d, dec_seg;
  logic [NUM_DIGITS-1:0]   en_q, en_d;
  logic                    slot_wrap, frame_wrap, go_on, sub_last, lz;
  logic [3:0]              nib;
  scoreboard_seg_decode u_dec (.bcd(nib), .seg(dec_seg));
  always_comb begin
    slot_wrap  = cnt_q == CW'(PRESCALE - 1);
    frame_wrap = slot_wrap && idx_q == IW'(NUM_DIGITS - 1);
    go_on      = cnt_q == CW'(BLANK_CYCLES - 1);
    sub_last   = sub_q == SW'(SUB - 1);
    cnt_d      = slot_wrap ? '0 : cnt_q + 1'b1;
    idx_d      = frame_wrap ? '0 : (slot_wrap ? idx_q + 1'b1 : idx_q);
    state_d    = go_on ? ST_ON : (slot_wrap ? ST_BLANK : state_q);
    bright_d   = go_on ? brightness : bright_q;
    sub_d      = (go_on || sub_last) ? '0 : sub_q + 1'b1;
    step_d     = go_on ? '0 : ((state_q == ST_ON && sub_last) ? step_q + 1'b1 : step_q);
    pending_d  = load ? digit_bcd : pending_q;
    active_d   = frame_wrap ? pending_q : active_q;
    upd_d      = load | (upd_q & ~frame_wrap);
    fs_d       = frame_wrap;
    nib        = active_q[{idx_q, 2'b00} +: 4];
`ifdef SCOREBOARD_LZ_BLANK_EN
    lz         = idx_q[0] && nib == 4'd0;
`else
    lz         = 1'b0;
`endif
    seg_d      = (state_q == ST_ON && !lz) ? dec_seg : '0;
    en_d       = (state_q == ST_ON && step_q < bright_q) ? NUM_DIGITS'(1) << idx_q : '0;
  end
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      cnt_q     <= '0;
      idx_q     <= '0;
      state_q   <= ST_BLANK;
      bright_q  <= '0;
      step_q    <= '0;
      sub_q     <= '0;
      active_q  <= '0;
      pending_q <= '0;
      upd_q     <= 1'b0;
      fs_q      <= 1'b0;
      seg_q     <= '0;
      en_q      <= '0;
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      state_q   <= state_d;
      bright_q  <= bright_d;
      step_q    <= step_d;
      sub_q     <= sub_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      upd_q     <= upd_d;
      fs_q      <= fs_d;
      seg_q     <= seg_d;
      en_q      <= en_d;
    end
  end
  assign seg         = seg_q;
  assign digit_en    = en_q;
  assign upd_pending = upd_q;
  assign frame_start = fs_q;
endmodule

// File: tb/tb_scoreboard_scan_ctrl.sv
// tb_scoreboard_scan_ctrl: directed checks of scan timing, brightness, frame-synchronous update and reset.
module tb_scoreboard_scan_ctrl;
  logic        clk = 1'b0, rst = 1'b1, load = 1'b0;
  logic [15:0] bcd = '0;
  logic [3:0]  bright = '0;
  logic [6:0]  seg;
  logic [3:0]  den;
  logic        upd, fs;
  int          checks = 0, fails = 0;
  logic [6:0]  exp_seg [4];
  int          en_cnt [4], seg_cnt [4], bad;
  logic        upd_mid;
  int          inj1_at = -1, inj2_at = -1;
  logic [15:0] inj1_val, inj2_val;
  scoreboard_scan_ctrl #(.NUM_DIGITS(4), .PRESCALE(48), .BLANK_CYCLES(16)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .digit_bcd(bcd), .load(load), .brightness(bright),
    .seg(seg), .digit_en(den), .upd_pending(upd), .frame_start(fs)
  );
  always #5 clk = ~clk;
  task automatic wait_frame();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (fs !== 1'b1 && n < 400);
    checks++;
    if (fs !== 1'b1) begin
      fails++;
      $display("FAIL frame_start_timeout: frame_start=%b required 1", fs);
    end
  endtask
  // Call on a frame_start cycle; sample j reflects counter state (slot j/48, count j%48).
  task automatic measure();
    int s;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      en_cnt[i] = 0;
      seg_cnt[i] = 0;
    end
    for (int j = 0; j < 192; j++) begin
      @(negedge clk);
      s = j / 48;
      if (den == 4'(1 << s)) en_cnt[s]++;
      else if (den != 4'd0) bad++;
      if (seg == exp_seg[s]) seg_cnt[s]++;
      if (j == 100) upd_mid = upd;
      load = (j == inj1_at) || (j == inj2_at);
      if (j == inj1_at) bcd = inj1_val;
      if (j == inj2_at) bcd = inj2_val;
    end
    load = 1'b0;
    inj1_at = -1;
    inj2_at = -1;
  endtask
  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks += 4;
    if (seg !== 7'd0) begin fails++; $display("FAIL reset_seg: got %b want 0", seg); end
    if (den !== 4'd0) begin fails++; $display("FAIL reset_den: got %b want 0", den); end
    if (upd !== 1'b0) begin fails++; $display("FAIL reset_upd: got %b want 0", upd); end
    if (fs !== 1'b0) begin fails++; $display("FAIL reset_fs: got %b want 0", fs); end
    rst = 1'b0;
  endtask
  task automatic test_load_frame();
    bright = 4'd15;
    bcd = 16'h4321;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    checks++;
    if (upd !== 1'b1) begin fails++; $display("FAIL load_upd_set: got %b want 1", upd); end
    wait_frame();
    checks++;
    if (upd !== 1'b0) begin fails++; $display("FAIL load_upd_clear: got %b want 0", upd); end
    exp_seg = '{7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110};
    measure();
    for (int i = 0; i < 4; i++) begin
      checks += 2;
      if (en_cnt[i] != 30) begin fails++; $display("FAIL frame_en_d%0d: got %0d cycles want 30", i, en_cnt[i]); end
      if (seg_cnt[i] != 32) begin fails++; $display("FAIL frame_seg_d%0d: got %0d cycles want 32", i, seg_cnt[i]); end
    end
    checks++;
    if (bad != 0) begin fails++; $display("FAIL frame_order: got %0d stray enables want 0", bad); end
  endtask
  task automatic test_brightness();
    bright = 4'd0;
    measure();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (en_cnt[i] != 0) begin fails++; $display("FAIL bright0_d%0d: got %0d want 0", i, en_cnt[i]); end
    end
    checks++;
    if (bad != 0) begin fails++; $display("FAIL bright0_stray: got %0d want 0", bad); end
    bright = 4'd8;
    measure();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (en_cnt[i] != 16) begin fails++; $display("FAIL bright8_d%0d: got %0d want 16", i, en_cnt[i]); end
    end
    bright = 4'd15;
  endtask
  task automatic test_double_load();
    bcd = 16'h1111;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    wait_frame();
    exp_seg = '{7'b0000110, 7'b0000110, 7'b0000110, 7'b0000110};
    inj1_at = 60;
    inj1_val = 16'h3333;
    inj2_at = 70;
    inj2_val = 16'h2222;
    measure();
    checks += 3;
    if (upd_mid !== 1'b1) begin fails++; $display("FAIL dbl_upd_mid: got %b want 1", upd_mid); end
    if (upd !== 1'b0) begin fails++; $display("FAIL dbl_upd_clear: got %b want 0", upd); end
    if (fs !== 1'b1) begin fails++; $display("FAIL dbl_fs: got %b want 1", fs); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (seg_cnt[i] != 32) begin fails++; $display("FAIL dbl_old_d%0d: got %0d want 32", i, seg_cnt[i]); end
    end
    exp_seg = '{7'b1011011, 7'b1011011, 7'b1011011, 7'b1011011};
    measure();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (seg_cnt[i] != 32) begin fails++; $display("FAIL dbl_new_d%0d: got %0d want 32", i, seg_cnt[i]); end
    end
  endtask
  task automatic test_load_at_transfer();
    bcd = 16'h6666;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (190) @(negedge clk);
    bcd = 16'h5555;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    checks += 2;
    if (fs !== 1'b1) begin fails++; $display("FAIL xfer_fs: got %b want 1", fs); end
    if (upd !== 1'b1) begin fails++; $display("FAIL xfer_upd_kept: got %b want 1", upd); end
    exp_seg = '{7'b1111101, 7'b1111101, 7'b1111101, 7'b1111101};
    measure();
    checks++;
    if (upd !== 1'b0) begin fails++; $display("FAIL xfer_upd_clear: got %b want 0", upd); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (seg_cnt[i] != 32) begin fails++; $display("FAIL xfer_old_d%0d: got %0d want 32", i, seg_cnt[i]); end
    end
    exp_seg = '{7'b1101101, 7'b1101101, 7'b1101101, 7'b1101101};
    measure();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (seg_cnt[i] != 32) begin fails++; $display("FAIL xfer_new_d%0d: got %0d want 32", i, seg_cnt[i]); end
    end
  endtask
  task automatic test_dash();
    bcd = 16'hA0F5;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (191) @(negedge clk);
    exp_seg = '{7'b1101101, 7'b1000000, 7'b0111111, 7'b1000000};
    measure();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (seg_cnt[i] != 32) begin fails++; $display("FAIL dash_d%0d: got %0d want 32", i, seg_cnt[i]); end
    end
  endtask
  task automatic test_lz();
    int want [4];
    bcd = 16'h0507;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (191) @(negedge clk);
`ifdef SCOREBOARD_LZ_BLANK_EN
    exp_seg = '{7'b0000111, 7'b0000000, 7'b1101101, 7'b0000000};
    want = '{32, 48, 32, 48};
`else
    exp_seg = '{7'b0000111, 7'b0111111, 7'b1101101, 7'b0111111};
    want = '{32, 32, 32, 32};
`endif
    measure();
    for (int i = 0; i < 4; i++) begin
      checks += 2;
      if (seg_cnt[i] != want[i]) begin fails++; $display("FAIL lz_seg_d%0d: got %0d want %0d", i, seg_cnt[i], want[i]); end
      if (en_cnt[i] != 30) begin fails++; $display("FAIL lz_en_d%0d: got %0d want 30", i, en_cnt[i]); end
    end
  endtask
  task automatic test_reset_mid();
    int n = 0;
    bcd = 16'h1234;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (19) @(negedge clk);
    checks++;
    if (den !== 4'b0001) begin fails++; $display("FAIL rstmid_pre_den: got %b want 0001", den); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks += 4;
    if (seg !== 7'd0) begin fails++; $display("FAIL rstmid_seg: got %b want 0", seg); end
    if (den !== 4'd0) begin fails++; $display("FAIL rstmid_den: got %b want 0", den); end
    if (upd !== 1'b0) begin fails++; $display("FAIL rstmid_upd: got %b want 0", upd); end
    if (fs !== 1'b0) begin fails++; $display("FAIL rstmid_fs: got %b want 0", fs); end
    do begin
      @(negedge clk);
      n++;
    end while (fs !== 1'b1 && n < 400);
    checks++;
    if (n != 192) begin fails++; $display("FAIL rstmid_first_frame: got %0d cycles want 192", n); end
    exp_seg = '{7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111};
    measure();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (seg_cnt[i] != 32) begin fails++; $display("FAIL rstmid_active_d%0d: got %0d want 32", i, seg_cnt[i]); end
    end
  endtask
  initial begin
    test_reset();
    test_load_frame();
    test_brightness();
    test_double_load();
    test_load_at_transfer();
    test_dash();
    test_lz();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
